fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-side arbiter that shares one 8-bit FIFO between several producers. It grants the FIFO write port to one requester at a time for a bounded burst, and drives the FIFO's write enable and write data. It never issues a write while the FIFO reports full. It sits directly in front of the FIFO write port; the FIFO read side is untouched.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, data width; must match the FIFO
- MAX_BURST, 4, maximum beats per grant (1..16)
- WDOG_CYCLES, 8, stall limit used only when the watchdog is compiled in
- Reset is rstN, asynchronous, active-low. The clock is clk.
- clk  in  1  clock; all state on rising edge
- rstN  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  requester i has a beat available
- req_last  in  NUM_REQ  beat from requester i is its final beat of the burst
- req_data  in  NUM_REQ*DATA_W  requester i data in slice [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  beat from requester i accepted this cycle
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  write strobe to the FIFO
- fifo_wr_data  out  DATA_W  write data to the FIFO
- grant_id  out  $clog2(NUM_REQ)  current owner index
- busy  out  1  high while in GRANT
- wdog_abort  out  1  one-cycle pulse when a grant is force-released; tied 0 without the macro

## Operation
- FSM states:
  - IDLE: no owner; req_ready=0.
  - GRANT: one owner holds the write port.
- IDLE -> GRANT when any req_valid bit is high.
  - The owner is the first valid index scanning upward, wrapping, from rr_ptr+1.
  - The owner is registered into grant_id.
  - beat_cnt clears to 0.
- In GRANT, the ready and write outputs are combinational:
  - req_ready[grant_id] = !fifo_full.
  - All other req_ready bits are 0.
  - fifo_wr_en = req_valid[grant_id] & !fifo_full.
  - fifo_wr_data = req_data slice of grant_id.
  - In IDLE, fifo_wr_data holds 0.
- A transfer occurs on a cycle where fifo_wr_en=1. Each transfer increments beat_cnt, which is $clog2(MAX_BURST)+1 bits wide.
- GRANT -> IDLE on a transfer when either of these holds:
  - req_last[grant_id]=1, or
  - beat_cnt == MAX_BURST-1 (burst cap).
  - On this exit, rr_ptr <= grant_id.
- If the owner drops req_valid mid-burst, the grant is held (locked) and no other requester is served.
- If fifo_full is high in GRANT, ready is 0, there is no write, and the state is held. Full never ends a grant.
- rr_ptr wraps modulo NUM_REQ. Its reset value is NUM_REQ-1, so requester 0 wins the first arbitration.
- busy = (state==GRANT).

## Timing
- Reset values:
  - state IDLE, rr_ptr NUM_REQ-1, beat_cnt 0, grant_id 0.
  - busy 0, req_ready 0, fifo_wr_en 0, fifo_wr_data 0, wdog_abort 0.
- Arbitration latency is one cycle. A req_valid seen in IDLE at edge N puts the block in GRANT after edge N, so the first transfer can happen in cycle N+1.
- Once granted, transfers sustain one beat per cycle while valid and not full.
- After each release there is one IDLE bubble. Peak throughput is MAX_BURST/(MAX_BURST+1).
- Simultaneous req_last and burst cap releases once. The boundary beat is always written.
- A requester that becomes valid in the release cycle is considered in the following IDLE cycle.
- rstN low mid-burst:
  - All outputs drop immediately (asynchronously) and the in-flight grant is discarded.
  - After release, arbitration restarts from requester 0.
- The combinational path fifo_full -> fifo_wr_en has zero cycles. The FIFO's full flag must be registered, so there is no combinational loop.

## Configuration
- Macro: FIFO_WR_ARB_WDOG_EN.
- Defined:
  - A stall counter counts consecutive GRANT cycles where req_valid[grant_id]=0. The counter is cleared on any owner-valid cycle and on entry to GRANT.
  - When the counter reaches WDOG_CYCLES, the block goes GRANT -> IDLE, rr_ptr <= grant_id, and wdog_abort pulses for one cycle.
  - Cycles stalled by fifo_full with the owner valid do not count.
- Undefined: no counter exists, a grant locks indefinitely, and wdog_abort is constant 0.

## Test plan
- Single requester:
  - Stimulus: after reset, req_valid=4'b0001 with 3 beats 0x11,0x22,0x33, last on the third.
  - Required: grant_id=0 one cycle later; fifo_wr_en on 3 consecutive cycles with those values; busy low after the third.
- Round-robin:
  - Stimulus: all four requesters valid continuously with MAX_BURST=4 and no last.
  - Required: grant order 0,1,2,3,0; each grant takes exactly 4 writes; one idle cycle between grants.
- Full backpressure:
  - Stimulus: fifo_full=1 for cycles 2–4 of a 4-beat burst from requester 2.
  - Required: fifo_wr_en=0 and req_ready=0 during those cycles; all 4 beats are written in order once full clears; no beat is lost or duplicated.
- Owner bubble:
  - Stimulus: requester 1 drops valid for 2 cycles mid-burst while requester 3 is valid.
  - Required: grant stays 1; requester 3 is not served until 1 asserts last.
- Reset mid-burst:
  - Stimulus: rstN low for 1 cycle after 2 of 4 beats from requester 3.
  - Required: fifo_wr_en=0 immediately; after reset, with requesters 0 and 3 valid, requester 0 is granted first.
- Watchdog (FIFO_WR_ARB_WDOG_EN, WDOG_CYCLES=8):
  - Stimulus: the owner goes invalid for 8 cycles.
  - Required: wdog_abort pulses once; the next valid requester is granted two cycles later.
  - Without the macro, the same stimulus keeps the grant and wdog_abort stays 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write-side arbiter that shares one FIFO write port between
//   NUM_REQ producers. One requester owns the port at a time for a burst of at
//   most MAX_BURST beats. A burst ends on the owner's req_last or on the burst
//   cap. No write is ever issued while fifo_full is high.
//
//   Optional feature: define FIFO_WR_ARB_WDOG_EN to compile in a stall
//   watchdog. It force-releases a grant after WDOG_CYCLES consecutive cycles
//   in which the owner has no valid beat. Without the macro, a stalled grant
//   holds indefinitely and wdog_abort is constant 0.
//
// Ports
//   clk           clock, rising edge
//   rstN          asynchronous active-low reset
//   req_valid     per-requester beat available
//   req_last      per-requester final beat of burst
//   req_data      packed requester data, requester i at [i*DATA_W +: DATA_W]
//   req_ready     per-requester beat accepted this cycle (combinational)
//   fifo_full     FIFO full flag (must be registered inside the FIFO)
//   fifo_wr_en    FIFO write strobe (combinational)
//   fifo_wr_data  FIFO write data (combinational, 0 while idle)
//   grant_id      current owner index
//   busy          high while a grant is active
//   wdog_abort    one-cycle pulse on a watchdog release

module fifo_wr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int MAX_BURST   = 4,
    parameter int WDOG_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_W-1:0]           fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        wdog_abort
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BC_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [BC_W-1:0]   beat_cnt;

    logic              in_grant;
    logic              owner_valid;
    logic              owner_last;
    logic [DATA_W-1:0] owner_data;
    logic              xfer;
    logic              burst_cap;
    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   scan_idx;

    assign in_grant = (state == GRANT);
    assign busy     = in_grant;

    // Select the owner's valid/last/data without variable-width indexing.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer      = in_grant & owner_valid & ~fifo_full;
    assign burst_cap = (beat_cnt == BC_W'(MAX_BURST - 1));

    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = in_grant & (grant_id == ID_W'(i)) & ~fifo_full;
        end
    end

    assign fifo_wr_en   = xfer;
    assign fifo_wr_data = in_grant ? owner_data : '0;

    // Round-robin scan: first valid requester starting just after rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!pick_found && req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx;
            end
        end
    end

`ifdef FIFO_WR_ARB_WDOG_EN
    localparam int SC_W = $clog2(WDOG_CYCLES + 1);

    logic [SC_W-1:0] stall_cnt;
    logic            wdog_pulse;

    assign wdog_abort = wdog_pulse;
`else
    // WDOG_CYCLES has no effect in this build; the expression is constant 0.
    assign wdog_abort = (WDOG_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            rr_ptr   <= ID_W'(NUM_REQ - 1);
            beat_cnt <= '0;
            grant_id <= '0;
`ifdef FIFO_WR_ARB_WDOG_EN
            stall_cnt  <= '0;
            wdog_pulse <= 1'b0;
`endif
        end else begin
`ifdef FIFO_WR_ARB_WDOG_EN
            wdog_pulse <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state    <= GRANT;
                        grant_id <= pick_id;
                        beat_cnt <= '0;
`ifdef FIFO_WR_ARB_WDOG_EN
                        stall_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        // Last and cap on the same beat still release only once.
                        if (owner_last || burst_cap) begin
                            state  <= IDLE;
                            rr_ptr <= grant_id;
                        end
                    end
`ifdef FIFO_WR_ARB_WDOG_EN
                    // Owner-valid cycles (including those blocked by full) reset the count.
                    if (owner_valid) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt == SC_W'(WDOG_CYCLES - 1)) begin
                        state      <= IDLE;
                        rr_ptr     <= grant_id;
                        stall_cnt  <= '0;
                        wdog_pulse <= 1'b1;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter with default parameters (4 requesters,
//   8-bit data, bursts of 4). Inputs change on the falling edge; outputs are
//   checked 1 time unit later, well away from the rising edge.

module tb_fifo_wr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic                       clk;
    logic                       rstN;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       fifo_full;
    logic                       fifo_wr_en;
    logic [DATA_W-1:0]          fifo_wr_data;
    logic [1:0]                 grant_id;
    logic                       busy;
    logic                       wdog_abort;

    int checks   = 0;
    int failures = 0;

    fifo_wr_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .MAX_BURST   (4),
        .WDOG_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .grant_id     (grant_id),
        .busy         (busy),
        .wdog_abort   (wdog_abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [DATA_W-1:0] v);
        req_data[i*DATA_W +: DATA_W] = v;
    endtask

    initial begin
        rstN      = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        #2;
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_ready", 32'(req_ready),    32'd0);
        check("rst_wr_en", 32'(fifo_wr_en),   32'd0);
        check("rst_data",  32'(fifo_wr_data), 32'd0);
        check("rst_grant", 32'(grant_id),     32'd0);
        check("rst_wdog",  32'(wdog_abort),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;

        // Single requester, three beats, last on the third.
        @(negedge clk); req_valid = 4'b0001; set_data(0, 8'h11);
        #1 check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_wr", 32'(fifo_wr_en), 32'd0);
        @(negedge clk);
        #1 check("t1_grant", 32'(grant_id), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready", 32'(req_ready), 32'b0001);
        check("t1_wr0", 32'(fifo_wr_en), 32'd1);
        check("t1_d0", 32'(fifo_wr_data), 32'h11);
        @(negedge clk); set_data(0, 8'h22);
        #1 check("t1_wr1", 32'(fifo_wr_en), 32'd1);
        check("t1_d1", 32'(fifo_wr_data), 32'h22);
        @(negedge clk); set_data(0, 8'h33); req_last = 4'b0001;
        #1 check("t1_wr2", 32'(fifo_wr_en), 32'd1);
        check("t1_d2", 32'(fifo_wr_data), 32'h33);
        @(negedge clk); req_valid = '0; req_last = '0;
        #1 check("t1_end_busy", 32'(busy), 32'd0);
        check("t1_end_wr", 32'(fifo_wr_en), 32'd0);

        // Round robin: all valid, no last, fresh reset so requester 0 leads.
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'(32'hA0 + i));
        for (int g = 0; g < 5; g++) begin
            #1 check("rr_bubble_busy", 32'(busy), 32'd0);
            check("rr_bubble_wr", 32'(fifo_wr_en), 32'd0);
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                #1 check("rr_grant", 32'(grant_id), 32'(g % 4));
                check("rr_wr", 32'(fifo_wr_en), 32'd1);
                check("rr_data", 32'(fifo_wr_data), 32'hA0 + 32'(g % 4));
            end
            @(negedge clk);
        end
        req_valid = '0;
        #1 check("rr_end_busy", 32'(busy), 32'd0);

        // Full backpressure on requester 2 for burst cycles 2..4.
        @(negedge clk); req_valid = 4'b0100; set_data(2, 8'hC0);
        #1 check("full_idle", 32'(busy), 32'd0);
        @(negedge clk);
        #1 check("full_grant", 32'(grant_id), 32'd2);
        check("full_wr0", 32'(fifo_wr_en), 32'd1);
        check("full_d0", 32'(fifo_wr_data), 32'hC0);
        check("full_ready0", 32'(req_ready), 32'b0100);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); set_data(2, 8'hC1); fifo_full = 1'b1;
            #1 check("full_stall_wr", 32'(fifo_wr_en), 32'd0);
            check("full_stall_ready", 32'(req_ready), 32'd0);
            check("full_stall_busy", 32'(busy), 32'd1);
        end
        @(negedge clk); fifo_full = 1'b0;
        #1 check("full_wr1", 32'(fifo_wr_en), 32'd1);
        check("full_d1", 32'(fifo_wr_data), 32'hC1);
        @(negedge clk); set_data(2, 8'hC2);
        #1 check("full_wr2", 32'(fifo_wr_en), 32'd1);
        check("full_d2", 32'(fifo_wr_data), 32'hC2);
        @(negedge clk); set_data(2, 8'hC3); req_last = 4'b0100;
        #1 check("full_wr3", 32'(fifo_wr_en), 32'd1);
        check("full_d3", 32'(fifo_wr_data), 32'hC3);
        @(negedge clk); req_valid = '0; req_last = '0;
        #1 check("full_end_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1 check("full_no_dup", 32'(fifo_wr_en), 32'd0);

        // Owner bubble: requester 1 stalls while requester 3 waits.
        @(negedge clk); req_valid = 4'b0010; set_data(1, 8'h10); set_data(3, 8'h30);
        #1 check("bub_idle", 32'(busy), 32'd0);
        @(negedge clk); req_valid = 4'b1010;
        #1 check("bub_grant", 32'(grant_id), 32'd1);
        check("bub_d0", 32'(fifo_wr_data), 32'h10);
        check("bub_wr0", 32'(fifo_wr_en), 32'd1);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); req_valid = 4'b1000; set_data(1, 8'h11);
            #1 check("bub_hold_grant", 32'(grant_id), 32'd1);
            check("bub_hold_wr", 32'(fifo_wr_en), 32'd0);
            check("bub_hold_ready", 32'(req_ready), 32'b0010);
            check("bub_hold_busy", 32'(busy), 32'd1);
        end
        @(negedge clk); req_valid = 4'b1010; req_last = 4'b0010;
        #1 check("bub_last_grant", 32'(grant_id), 32'd1);
        check("bub_last_d", 32'(fifo_wr_data), 32'h11);
        @(negedge clk); req_valid = 4'b1000; req_last = '0;
        #1 check("bub_gap", 32'(busy), 32'd0);
        @(negedge clk); req_last = 4'b1000;
        #1 check("bub_next_grant", 32'(grant_id), 32'd3);
        check("bub_next_d", 32'(fifo_wr_data), 32'h30);
        check("bub_next_wr", 32'(fifo_wr_en), 32'd1);
        @(negedge clk); req_valid = '0; req_last = '0;
        #1 check("bub_end", 32'(busy), 32'd0);

        // Reset in the middle of a burst from requester 3.
        @(negedge clk); req_valid = 4'b1000; set_data(3, 8'hD0);
        #1 check("mrst_idle", 32'(busy), 32'd0);
        @(negedge clk);
        #1 check("mrst_grant", 32'(grant_id), 32'd3);
        check("mrst_d0", 32'(fifo_wr_data), 32'hD0);
        @(negedge clk); set_data(3, 8'hD1);
        #1 check("mrst_wr1", 32'(fifo_wr_en), 32'd1);
        @(negedge clk); rstN = 1'b0;
        #1 check("mrst_wr_drop", 32'(fifo_wr_en), 32'd0);
        check("mrst_busy_drop", 32'(busy), 32'd0);
        check("mrst_ready_drop", 32'(req_ready), 32'd0);
        check("mrst_data_drop", 32'(fifo_wr_data), 32'd0);
        check("mrst_grant_drop", 32'(grant_id), 32'd0);
        @(negedge clk); rstN = 1'b1; req_valid = 4'b1001; set_data(0, 8'hE0);
        #1 check("mrst_after_idle", 32'(busy), 32'd0);
        @(negedge clk);
        #1 check("mrst_first", 32'(grant_id), 32'd0);
        check("mrst_first_d", 32'(fifo_wr_data), 32'hE0);
        @(negedge clk); set_data(0, 8'hE1); req_last = 4'b0001;
        #1 check("mrst_last_wr", 32'(fifo_wr_en), 32'd1);
        @(negedge clk); req_valid = '0; req_last = '0;
        #1 check("mrst_end", 32'(busy), 32'd0);

        // Owner 0 goes invalid for 8 cycles while requester 2 is valid.
        @(negedge clk); req_valid = 4'b0001; set_data(0, 8'h55); set_data(2, 8'h77);
        #1 check("wd_idle", 32'(busy), 32'd0);
        @(negedge clk);
        #1 check("wd_grant", 32'(grant_id), 32'd0);
        check("wd_wr0", 32'(fifo_wr_en), 32'd1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); req_valid = 4'b0100;
            #1 check("wd_stall_busy", 32'(busy), 32'd1);
            check("wd_stall_grant", 32'(grant_id), 32'd0);
            check("wd_stall_wr", 32'(fifo_wr_en), 32'd0);
            check("wd_stall_abort", 32'(wdog_abort), 32'd0);
        end
`ifdef FIFO_WR_ARB_WDOG_EN
        @(negedge clk);
        #1 check("wd_abort_pulse", 32'(wdog_abort), 32'd1);
        check("wd_abort_idle", 32'(busy), 32'd0);
        @(negedge clk); req_last = 4'b0100;
        #1 check("wd_abort_once", 32'(wdog_abort), 32'd0);
        check("wd_next_grant", 32'(grant_id), 32'd2);
        check("wd_next_d", 32'(fifo_wr_data), 32'h77);
        @(negedge clk); req_valid = '0; req_last = '0;
        #1 check("wd_end", 32'(busy), 32'd0);
`else
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1 check("nowd_hold_busy", 32'(busy), 32'd1);
            check("nowd_hold_grant", 32'(grant_id), 32'd0);
            check("nowd_abort", 32'(wdog_abort), 32'd0);
        end
        @(negedge clk); req_valid = 4'b0101; req_last = 4'b0001;
        #1 check("nowd_resume_wr", 32'(fifo_wr_en), 32'd1);
        check("nowd_resume_d", 32'(fifo_wr_data), 32'h55);
        @(negedge clk); req_valid = '0; req_last = '0;
        #1 check("nowd_end", 32'(busy), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
